mem_dumper: RTL

UART-side memory readback engine; the read counterpart of the boot flasher that writes instruction/data memory over UART. Receives a 4-byte start address and 4-byte byte count from the byte-level UART receiver. Reads instruction memory (below `INSTR_LIMIT`) or data memory (at or above it) one word at a time and streams the bytes back through the UART transmitter. Holds the core stalled while a dump is in progress.

---
 rtl/mem_dumper.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_dumper.sv
// UART memory readback: takes a 4-byte address and 4-byte count, then streams bytes from instr/data memory.
// Define MEM_DUMP_CHECKSUM_EN to append an XOR checksum byte after the data.
module mem_dumper #(
  parameter logic [31:0] INSTR_LIMIT = 32'h0000_0400
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_busy_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  output logic [31:0] data_addr_o,
  input  logic [31:0] data_rdata_i,
  output logic        core_stall_o,
  output logic        busy_o
);

`ifdef MEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    RCV_ADDR, RCV_SIZE, FETCH, FETCH_WAIT, SEND, WAIT_TX, SEND_SUM, DONE
  } state_t;
  localparam state_t LAST_ST = SEND_SUM;
  logic [7:0] sum;
`else
  typedef enum logic [2:0] {
    RCV_ADDR, RCV_SIZE, FETCH, FETCH_WAIT, SEND, WAIT_TX, DONE
  } state_t;
  localparam state_t LAST_ST = DONE;
`endif

  state_t      state;
  logic [31:0] addr;
  logic [31:0] count;
  logic [31:0] word;
  logic [1:0]  byte_cnt;
  logic        wait_first;
  logic        cur_data;

  logic [31:0] count_nxt;
  logic [31:0] addr_word;
  logic        addr_is_data;
  logic [7:0]  tx_byte;

  assign count_nxt    = {count[23:0], rx_data_i};
  assign addr_word    = {addr[31:2], 2'b00};
  assign addr_is_data = (addr >= INSTR_LIMIT);
  assign tx_byte      = word[{addr[1:0], 3'b000} +: 8];

  // The memory address is registered on the edge entering FETCH so the
  // synchronous memory samples it at the end of FETCH and rdata is ready in FETCH_WAIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= RCV_ADDR;
      addr         <= '0;
      count        <= '0;
      word         <= '0;
      byte_cnt     <= '0;
      wait_first   <= 1'b0;
      cur_data     <= 1'b0;
      tx_data_o    <= '0;
      tx_valid_o   <= 1'b0;
      instr_addr_o <= '0;
      data_addr_o  <= '0;
      core_stall_o <= 1'b0;
      busy_o       <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      tx_valid_o <= 1'b0;
      case (state)
        RCV_ADDR: if (rx_valid_i) begin
          addr         <= {addr[23:0], rx_data_i};
          byte_cnt     <= byte_cnt + 2'd1;
          core_stall_o <= 1'b1;
          busy_o       <= 1'b1;
          if (byte_cnt == 2'd3) state <= RCV_SIZE;
        end
        RCV_SIZE: if (rx_valid_i) begin
          count    <= count_nxt;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
`ifdef MEM_DUMP_CHECKSUM_EN
            sum <= '0;
`endif
            if (count_nxt == 32'd0) begin
              state <= LAST_ST;
            end else begin
              state    <= FETCH;
              cur_data <= addr_is_data;
              if (addr_is_data) data_addr_o  <= addr_word;
              else              instr_addr_o <= addr_word;
            end
          end
        end
        FETCH: state <= FETCH_WAIT;
        FETCH_WAIT: begin
          word  <= cur_data ? data_rdata_i : instr_rdata_i;
          state <= SEND;
        end
        SEND: if (!tx_busy_i) begin
          tx_data_o  <= tx_byte;
          tx_valid_o <= 1'b1;
          addr       <= addr + 32'd1;
          count      <= count - 32'd1;
          wait_first <= 1'b1;
          state      <= WAIT_TX;
`ifdef MEM_DUMP_CHECKSUM_EN
          sum        <= sum ^ tx_byte;
`endif
        end
        // The transmitter raises busy a cycle after the strobe, so the first cycle here is blind.
        WAIT_TX: if (wait_first) begin
          wait_first <= 1'b0;
        end else if (!tx_busy_i) begin
          if (count == 32'd0) begin
            state <= LAST_ST;
          end else if (addr[1:0] == 2'b00 || addr_is_data != cur_data) begin
            state    <= FETCH;
            cur_data <= addr_is_data;
            if (addr_is_data) data_addr_o  <= addr_word;
            else              instr_addr_o <= addr_word;
          end else begin
            state <= SEND;
          end
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        SEND_SUM: if (!tx_busy_i) begin
          tx_data_o  <= sum;
          tx_valid_o <= 1'b1;
          state      <= DONE;
        end
`endif
        DONE: begin
          core_stall_o <= 1'b0;
          busy_o       <= 1'b0;
          state        <= RCV_ADDR;
        end
        default: state <= RCV_ADDR;
      endcase
    end
  end

endmodule
